// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush control slice.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
  } hazard_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Flags when the ID instruction reads the destination of a load sitting in EX.
module load_use_detector
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_memory_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use_c
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real producer, so a load targeting it cannot create a hazard
  always_comb begin
    rs1_hit    = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit    = id_uses_rs2 && (id_rs2 == ex_rd);
    load_use_c = ex_memory_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect, fetch
// and data-memory wait handling with a timeout watchdog and stall counter.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned PERF_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ID_rs1,
  input  logic [REG_ADDR_W-1:0] ID_rs2,
  input  logic                  ID_uses_rs1,
  input  logic                  ID_uses_rs2,
  input  logic                  EX_memory_read,
  input  logic [REG_ADDR_W-1:0] EX_rd,
  input  logic                  EX_redirect,
  input  logic                  MEM_memory_read,
  input  logic                  MEM_memory_write,
  input  logic                  dmem_ready,
  input  logic                  imem_ready,
  output logic                  dmem_request,
  output logic                  pc_stall,
  output logic                  IF_ID_stall,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_stall,
  output logic                  ID_EX_flush,
  output logic                  EX_MEM_stall,
  output logic                  MEM_WB_flush,
  output logic                  mem_timeout_error,
  output logic [PERF_W-1:0]     perf_stall_cycles
);

  mem_state_e            state;
  logic [TIMEOUT_W-1:0]  wait_cnt;
  logic                  mem_op;
  logic                  timeout_fire;
  logic                  mem_stall;
  logic                  load_use;
  hazard_ctrl_t          ctrl;

  load_use_detector u_load_use_detector (
    .id_rs1         (ID_rs1),
    .id_rs2         (ID_rs2),
    .id_uses_rs1    (ID_uses_rs1),
    .id_uses_rs2    (ID_uses_rs2),
    .ex_memory_read (EX_memory_read),
    .ex_rd          (EX_rd),
    .load_use_c     (load_use)
  );

  // The watchdog abort releases the stall in the same cycle it fires
  always_comb begin
    mem_op       = MEM_memory_read | MEM_memory_write;
    timeout_fire = (state == MEM_WAIT) && mem_op && !dmem_ready &&
                   (wait_cnt == TIMEOUT_W'(MEM_TIMEOUT));
    mem_stall    = mem_op && !dmem_ready && !timeout_fire;
  end

  // Priority: memory stall, then redirect, then load-use, then fetch miss
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      if (mem_stall) begin
        ctrl.pc_stall     = 1'b1;
        ctrl.if_id_stall  = 1'b1;
        ctrl.id_ex_stall  = 1'b1;
        ctrl.ex_mem_stall = 1'b1;
        ctrl.mem_wb_flush = 1'b1;
      end else if (EX_redirect) begin
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_flush  = 1'b1;
      end else if (load_use) begin
        ctrl.pc_stall     = 1'b1;
        ctrl.if_id_stall  = 1'b1;
        ctrl.id_ex_flush  = 1'b1;
      end else if (!imem_ready) begin
        ctrl.pc_stall     = 1'b1;
        ctrl.if_id_flush  = 1'b1;
      end
    end
  end

  assign dmem_request = mem_op && !reset;
  assign pc_stall     = ctrl.pc_stall;
  assign IF_ID_stall  = ctrl.if_id_stall;
  assign IF_ID_flush  = ctrl.if_id_flush;
  assign ID_EX_stall  = ctrl.id_ex_stall;
  assign ID_EX_flush  = ctrl.id_ex_flush;
  assign EX_MEM_stall = ctrl.ex_mem_stall;
  assign MEM_WB_flush = ctrl.mem_wb_flush;

  // Data-memory wait FSM, watchdog and stall-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= RUN;
      wait_cnt          <= '0;
      mem_timeout_error <= 1'b0;
      perf_stall_cycles <= '0;
    end else begin
      if (ctrl.pc_stall) begin
        perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
      end
      case (state)
        RUN: begin
          if (mem_op && !dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= TIMEOUT_W'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (!mem_op || dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (timeout_fire) begin
            state             <= RUN;
            wait_cnt          <= '0;
            mem_timeout_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized and directed bench for pipeline_hazard_controller against a
// cycle-level reference model built from the hazard priority rules.
module tb_pipeline_hazard_controller;

  localparam int unsigned T_OUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd;
  logic        ID_uses_rs1, ID_uses_rs2, EX_memory_read, EX_redirect;
  logic        MEM_memory_read, MEM_memory_write, dmem_ready, imem_ready;
  logic        dmem_request, pc_stall, IF_ID_stall, IF_ID_flush;
  logic        ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush;
  logic        mem_timeout_error;
  logic [31:0] perf_stall_cycles;

  int          checks   = 0;
  int          failures = 0;

  // reference model state: consecutive stalled cycles of the current access
  int          m_wait;
  logic        m_err;
  logic [31:0] m_perf;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .MEM_TIMEOUT (T_OUT),
    .TIMEOUT_W   (8),
    .PERF_W      (32)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ID_rs1            (ID_rs1),
    .ID_rs2            (ID_rs2),
    .ID_uses_rs1       (ID_uses_rs1),
    .ID_uses_rs2       (ID_uses_rs2),
    .EX_memory_read    (EX_memory_read),
    .EX_rd             (EX_rd),
    .EX_redirect       (EX_redirect),
    .MEM_memory_read   (MEM_memory_read),
    .MEM_memory_write  (MEM_memory_write),
    .dmem_ready        (dmem_ready),
    .imem_ready        (imem_ready),
    .dmem_request      (dmem_request),
    .pc_stall          (pc_stall),
    .IF_ID_stall       (IF_ID_stall),
    .IF_ID_flush       (IF_ID_flush),
    .ID_EX_stall       (ID_EX_stall),
    .ID_EX_flush       (ID_EX_flush),
    .EX_MEM_stall      (EX_MEM_stall),
    .MEM_WB_flush      (MEM_WB_flush),
    .mem_timeout_error (mem_timeout_error),
    .perf_stall_cycles (perf_stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_idle();
    reset = 1'b0; ID_rs1 = 5'd1; ID_rs2 = 5'd2; EX_rd = 5'd0;
    ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0; EX_memory_read = 1'b0;
    EX_redirect = 1'b0; MEM_memory_read = 1'b0; MEM_memory_write = 1'b0;
    dmem_ready = 1'b1; imem_ready = 1'b1;
  endtask

  // Called with inputs already driven after a negedge: checks, then advances model
  task automatic step();
    logic       mop, abort, mstall, lu;
    logic [6:0] exp_v, obs_v;
    #1;
    mop    = MEM_memory_read || MEM_memory_write;
    abort  = mop && !dmem_ready && (m_wait == int'(T_OUT));
    mstall = mop && !dmem_ready && !abort;
    lu     = EX_memory_read && (EX_rd != 5'd0) &&
             ((ID_uses_rs1 && ID_rs1 == EX_rd) || (ID_uses_rs2 && ID_rs2 == EX_rd));
    // order: pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush
    if (reset)             exp_v = 7'b000_0000;
    else if (mstall)       exp_v = 7'b110_1011;
    else if (EX_redirect)  exp_v = 7'b001_0100;
    else if (lu)           exp_v = 7'b110_0100;
    else if (!imem_ready)  exp_v = 7'b101_0000;
    else                   exp_v = 7'b000_0000;
    obs_v = {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
             EX_MEM_stall, MEM_WB_flush};
    check("ctrl_vector", 32'(obs_v), 32'(exp_v));
    check("dmem_request", 32'(dmem_request), 32'(mop && !reset));
    check("perf_stall_cycles", perf_stall_cycles, m_perf);
    check("mem_timeout_error", 32'(mem_timeout_error), 32'(m_err));
    if (reset) begin
      m_wait = 0; m_err = 1'b0; m_perf = 32'd0;
    end else begin
      if (exp_v[6]) m_perf = m_perf + 32'd1;
      if (abort) begin
        m_err = 1'b1; m_wait = 0;
      end else if (mstall) begin
        m_wait++;
      end else begin
        m_wait = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); set_idle(); reset = 1'b1; step();
    @(negedge clk); set_idle(); step();
  endtask

  initial begin
    set_idle();
    reset  = 1'b1;
    m_wait = 0; m_err = 1'b0; m_perf = 32'd0;
    @(negedge clk); step();
    check("reset_pc_stall", 32'(pc_stall), 32'd0);

    // load-use on rs1, then the same with EX_rd = x0
    @(negedge clk); set_idle();
    EX_memory_read = 1'b1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_uses_rs1 = 1'b1;
    step();
    check("lu_pc_stall", 32'(pc_stall), 32'd1);
    check("lu_id_ex_flush", 32'(ID_EX_flush), 32'd1);
    @(negedge clk); set_idle();
    EX_memory_read = 1'b1; EX_rd = 5'd0; ID_rs1 = 5'd0; ID_uses_rs1 = 1'b1;
    step();
    check("lu_x0_pc_stall", 32'(pc_stall), 32'd0);

    // 3 wait cycles then ready: exactly 3 stall cycles counted
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_idle();
      MEM_memory_read = 1'b1; dmem_ready = (i == 3);
      step();
      check("memwait_ex_mem_stall", 32'(EX_MEM_stall), (i < 3) ? 32'd1 : 32'd0);
      check("memwait_dmem_request", 32'(dmem_request), 32'd1);
    end
    @(negedge clk); set_idle(); step();
    check("memwait_perf", perf_stall_cycles, 32'd3);

    // redirect beats load-use
    @(negedge clk); set_idle();
    EX_redirect = 1'b1; EX_memory_read = 1'b1; EX_rd = 5'd7;
    ID_rs2 = 5'd7; ID_uses_rs2 = 1'b1;
    step();
    check("redir_lu_if_id_flush", 32'(IF_ID_flush), 32'd1);
    check("redir_lu_pc_stall", 32'(pc_stall), 32'd0);

    // redirect held behind a 2-cycle memory stall
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_idle();
      EX_redirect = 1'b1; MEM_memory_write = 1'b1; dmem_ready = (i == 2);
      step();
      check("redir_mem_id_ex_flush", 32'(ID_EX_flush), (i == 2) ? 32'd1 : 32'd0);
    end

    // fetch miss together with load-use: stall wins over flush
    @(negedge clk); set_idle();
    imem_ready = 1'b0; EX_memory_read = 1'b1; EX_rd = 5'd3;
    ID_rs1 = 5'd3; ID_uses_rs1 = 1'b1;
    step();
    check("imem_lu_if_id_flush", 32'(IF_ID_flush), 32'd0);

    // timeout: stall cycles 1..4, release on 5, error sticky
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); set_idle();
      MEM_memory_read = (i <= 5); dmem_ready = 1'b0;
      step();
      check("timeout_pc_stall", 32'(pc_stall), (i <= 4) ? 32'd1 : 32'd0);
    end
    check("timeout_error", 32'(mem_timeout_error), 32'd1);
    @(negedge clk); set_idle(); step();
    check("timeout_error_sticky", 32'(mem_timeout_error), 32'd1);

    // reset in the middle of a wait
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); set_idle(); MEM_memory_read = 1'b1; dmem_ready = 1'b0; step();
    end
    @(negedge clk); set_idle(); MEM_memory_read = 1'b1; dmem_ready = 1'b0;
    reset = 1'b1; step();
    check("rst_mid_dmem_request", 32'(dmem_request), 32'd0);
    @(negedge clk); set_idle(); step();
    check("rst_mid_perf", perf_stall_cycles, 32'd0);
    check("rst_mid_error", 32'(mem_timeout_error), 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset          = ($urandom_range(199) == 0);
      ID_rs1         = 5'($urandom_range(3));
      ID_rs2         = 5'($urandom_range(3));
      EX_rd          = 5'($urandom_range(3));
      ID_uses_rs1    = 1'($urandom_range(1));
      ID_uses_rs2    = 1'($urandom_range(1));
      EX_memory_read = 1'($urandom_range(1));
      EX_redirect    = ($urandom_range(5) == 0);
      imem_ready     = ($urandom_range(3) != 0);
      dmem_ready     = 1'($urandom_range(1));
      if (m_wait > 0 && $urandom_range(9) != 0) begin
        MEM_memory_read  = 1'b1;
        MEM_memory_write = 1'b0;
      end else begin
        MEM_memory_read  = ($urandom_range(3) == 0);
        MEM_memory_write = ($urandom_range(4) == 0);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
